// File: rtl/pipe_rf_pkg.sv
// rtl/pipe_rf_pkg.sv - shared defaults, constants and port-slicing helpers for the register file
package pipe_rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  // LSB of read port k inside the packed rd_addr bus.
  function automatic int rd_addr_lsb(input int port, input int addr_w);
    return port * addr_w;
  endfunction

  // LSB of read port k inside the packed rd_data bus.
  function automatic int rd_data_lsb(input int port, input int data_w);
    return port * data_w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with reserve, clear, flush and stall logic
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_flush            clear every busy bit at the edge
//   i_wr_en/i_wr_addr  writeback: clears the destination busy bit
//   i_rsv_en/addr      decode: reserve a destination
//   o_busy             busy bit vector, one per register
//   o_rsv_stall        reservation refused this cycle (combinational)
module rf_scoreboard
  import pipe_rf_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic                   i_rsv_en,
  input  logic [ADDR_W-1:0]      i_rsv_addr,
  output logic [(1<<ADDR_W)-1:0] o_busy,
  output logic                   o_rsv_stall
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic             w_wr_ok;
  logic             w_rsv_ok;
  logic             w_wr_frees_rsv;

  // Register 0 is not a real destination when hard-wired: writes and
  // reservations to it are silently dropped.
  assign w_wr_ok  = i_wr_en  && !((ZERO_REG != 0) && (i_wr_addr  == ADDR_W'(REG_ZERO)));
  assign w_rsv_ok = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == ADDR_W'(REG_ZERO)));

  // A producer retiring this cycle hands its register straight to the new one.
  assign w_wr_frees_rsv = w_wr_ok && (i_wr_addr == i_rsv_addr);

  assign o_rsv_stall = !i_reset && !i_flush && w_rsv_ok &&
                       r_busy[i_rsv_addr] && !w_wr_frees_rsv;

  // Set is applied after clear so a same-cycle write+reserve ends busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[i_wr_addr] = 1'b0;
    end
    if (w_rsv_ok && !o_rsv_stall) begin
      w_busy_nxt[i_rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - multi-read-port register file with bypass, zero register and busy scoreboard
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_wr_en/addr/data     writeback port
//   i_rd_addr             NUM_RD packed read addresses
//   o_rd_data             NUM_RD packed read data (combinational)
//   o_rd_busy             per-port outstanding-reservation flag
//   i_rsv_en/i_rsv_addr   decode destination reservation
//   o_rsv_stall           reservation refused this cycle
//   i_flush               clear all reservations
module pipe_regfile
  import pipe_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_wr_en,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
  output logic [NUM_RD-1:0]          o_rd_busy,
  input  logic                       i_rsv_en,
  input  logic [ADDR_W-1:0]          i_rsv_addr,
  output logic                       o_rsv_stall,
  input  logic                       i_flush
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_addr;

  assign w_wr_ok = i_wr_en && !((ZERO_REG != 0) && (i_wr_addr == ADDR_W'(REG_ZERO)));

  // Flush only affects reservations; a writeback in the flush cycle still lands.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_flush     (i_flush),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_rsv_en    (i_rsv_en),
    .i_rsv_addr  (i_rsv_addr),
    .o_busy      (w_busy),
    .o_rsv_stall (o_rsv_stall)
  );

  // A forwarded value comes from the producer that is retiring right now,
  // so the reader sees it as not busy even if a reservation is still stored.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    w_addr    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_addr = i_rd_addr[rd_addr_lsb(k, ADDR_W) +: ADDR_W];
      if ((ZERO_REG != 0) && (w_addr == ADDR_W'(REG_ZERO))) begin
        o_rd_data[rd_data_lsb(k, DATA_W) +: DATA_W] = '0;
        o_rd_busy[k] = 1'b0;
      end else if ((BYPASS != 0) && w_wr_ok && (i_wr_addr == w_addr)) begin
        o_rd_data[rd_data_lsb(k, DATA_W) +: DATA_W] = i_wr_data;
        o_rd_busy[k] = 1'b0;
      end else begin
        o_rd_data[rd_data_lsb(k, DATA_W) +: DATA_W] = r_mem[w_addr];
        o_rd_busy[k] = w_busy[w_addr];
      end
    end
  end

endmodule

// File: doc/pipe_regfile.md
# pipe_regfile

Parametrised general-purpose register file for the pipelined MIPS core, successor to the single-write-port register array. It adds a configurable number of asynchronous read ports, same-cycle write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard for hazard detection. Decode reads operands and reserves destinations, and writeback writes results. A flush from the hazard/branch unit clears all reservations.

## Interface

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching reads.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_W  writeback destination.
- wr_data  in  DATA_W  writeback data.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has an outstanding reservation.
- rsv_en  in  1  decode requests reservation of rsv_addr.
- rsv_addr  in  ADDR_W  destination to reserve.
- rsv_stall  out  1  combinational; reservation refused this cycle.
- flush  in  1  clears all busy bits.

## Operation

- Storage: 2**ADDR_W x DATA_W registers plus one busy bit per register.
- Write: wr_en=1 and the address is writable (it is not register 0 with ZERO_REG=1). The register takes wr_data at the edge and its busy bit clears, unless it is re-reserved in the same cycle.
- Read port k:
  - ZERO_REG=1 and addr 0 gives data 0.
  - BYPASS=1 and wr_en and wr_addr==rd_addr[k] (writable) gives wr_data, with rd_busy[k]=0.
  - Otherwise it gives the stored value and the stored busy bit.
- Reservation:
  - rsv_en=1 on a writable address whose busy bit is 0 sets the bit at the edge.
  - If the busy bit is 1 and is not being cleared by a same-cycle wr_en to the same address, rsv_stall=1 and nothing changes. Decode holds and retries.
  - Reservation of register 0 with ZERO_REG=1 is accepted as a no-op, with rsv_stall=0.
- Same address written and reserved in one cycle: the write updates the data and the busy bit ends at 1 (new producer). rsv_stall=0.
- flush=1: all busy bits clear at the edge. A same-cycle rsv_en is ignored and rsv_stall=0. A same-cycle write still updates the data.
- Priority per edge: reset > flush > reservation set > write clear.
- Reset: all registers become 0 and all busy bits become 0. Writes, reservations and flush in the reset cycle are ignored. rsv_stall is forced to 0 while reset=1.

## Timing

- Write latency: 1 edge to storage, 0 cycles to readers when BYPASS=1. With BYPASS=0, readers see the new value the cycle after the edge.
- Read latency: combinational. rd_data and rd_busy depend on rd_addr, storage and the current wr_* inputs.
- rsv_stall is combinational from rsv_en, rsv_addr, wr_en, wr_addr, flush and reset.
- Outputs after reset: every rd_data = 0, every rd_busy = 0, rsv_stall = 0 (with rsv_en=0).
- Reset asserted mid-operation takes effect at the next edge regardless of pending reservations. Any busy state is lost; the pipeline is flushed by the same reset.

## Structure

- Shared package pipe_rf_pkg: default DATA_W and ADDR_W, the constant REG_ZERO = 0, and the rd-port slicing helper functions.
- One sub-module, rf_scoreboard: the busy-bit vector with the reservation, clear, flush and reset logic, and rsv_stall generation. The data array and the read/bypass muxes stay in pipe_regfile.

## Test plan

- Reset: write r5=0x1234 and reserve r6, then pulse reset. The next cycle reads r5=0 and rd_busy=0 for r5 and r6.
- Bypass: wr_en r7=0xDEADBEEF while port 1 reads r7 in the same cycle. Port 1 gives 0xDEADBEEF with busy=0. With BYPASS=0 it gives the old value, then 0xDEADBEEF the next cycle.
- Zero register: write r0=0xFFFFFFFF and reserve r0. r0 reads 0, never busy, rsv_stall=0.
- Scoreboard:
  - Reserve r3: rd_busy=1 next cycle. A second reserve of r3 gives rsv_stall=1.
  - A write to r3 plus reserve of r3 in the same cycle gives rsv_stall=0, data updated, busy stays 1.
- Flush: reserve r1, r2 and r31, then flush together with rsv_en r4. Next cycle all busy=0, including r4, and rsv_stall=0.
- Multi-port: NUM_RD=3 reads r1, r1 and r2 after writes of 0x11 and 0x22. The ports give 0x11, 0x11 and 0x22.
